// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module : param_register_file
// Desc   : Parametrised 2W/3R register file with auto-incrementing PC register
// Rev    : 1.0 - initial release
// ============================================================================
module param_register_file #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NUM_REGS = 16,
  parameter int unsigned       PC_INDEX = 15,
  parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4),
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter bit                R0_ZERO  = 1'b1,
  parameter bit                BYPASS   = 1'b1,
  localparam int unsigned      AW       = $clog2(NUM_REGS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE0,
  input  logic [AW-1:0]     WA0,
  input  logic [DATA_W-1:0] WD0,
  input  logic              WE1,
  input  logic [AW-1:0]     WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              PC_INC_EN,
  input  logic [AW-1:0]     RA_A,
  input  logic [AW-1:0]     RA_B,
  input  logic [AW-1:0]     RA_S,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic [DATA_W-1:0] PS,
  output logic [DATA_W-1:0] PC_Q,
  output logic              WR_CONFLICT
);

  localparam logic [AW-1:0] c_pc_addr = AW'(PC_INDEX);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_next [NUM_REGS];
  logic              r_wr_conflict;

  // Later assignments win: port 1 over port 0 over PC increment over hold.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_next[i] = r_regs[i];
      if ((i == PC_INDEX) && PC_INC_EN) w_next[i] = r_regs[i] + PC_STEP;
      if (WE0 && (WA0 == AW'(i)))       w_next[i] = WD0;
      if (WE1 && (WA1 == AW'(i)))       w_next[i] = WD1;
      if (R0_ZERO && (i == 0))          w_next[i] = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == PC_INDEX) ? RESET_PC : '0;
      end
      r_wr_conflict <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_wr_conflict <= WE0 && WE1 && (WA0 == WA1);
    end
  end

  // Bypass forwards only explicit port writes; PC increments are never forwarded.
  function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] v;
    v = r_regs[addr];
    if (BYPASS) begin
      if (WE1 && (WA1 == addr))      v = WD1;
      else if (WE0 && (WA0 == addr)) v = WD0;
    end
    if (R0_ZERO && (addr == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    PA = f_read(RA_A);
    PB = f_read(RA_B);
    PS = f_read(RA_S);
  end

  assign PC_Q        = r_regs[c_pc_addr];
  assign WR_CONFLICT = r_wr_conflict;

endmodule
`default_nettype wire

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised successor to the 16x32 single-write register file in the ARM datapath.
- Configurable width and depth.
- Two write ports with fixed priority; three read ports (A, B operands; S shift-amount register).
- Dedicated program-counter register with auto-increment.
- Optional write-to-read bypass and optional hardwired-zero R0.

Sits between the decode stage (addresses) and the ALU/shifter (operands); writeback stage drives the write ports.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, register count; power of 2, >=4; AW = log2(NUM_REGS)
PC_INDEX, 15, register index acting as program counter
PC_STEP, 4, PC increment per enabled cycle
RESET_PC, 0, PC value after reset
R0_ZERO, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = reads return same-cycle write data

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous, active-low reset
WE0  input  1  write-port-0 enable
WA0  input  AW  write-port-0 address
WD0  input  DATA_W  write-port-0 data
WE1  input  1  write-port-1 enable (higher priority)
WA1  input  AW  write-port-1 address
WD1  input  DATA_W  write-port-1 data
PC_INC_EN  input  1  advance PC this cycle
RA_A  input  AW  read address, port A
RA_B  input  AW  read address, port B
RA_S  input  AW  read address, port S
PA  output  DATA_W  read data, port A
PB  output  DATA_W  read data, port B
PS  output  DATA_W  read data, port S
PC_Q  output  DATA_W  current PC register value
WR_CONFLICT  output  1  registered flag: both write ports hit the same address last cycle

Behaviour:
Reset
- RST_N low clears immediately, independent of CLK.
- All registers go to 0, except PC_INDEX, which goes to RESET_PC.
- WR_CONFLICT goes to 0. PC_Q = RESET_PC.
- PA/PB/PS reflect reset contents combinationally.
- Reset asserted mid-write: that write is lost. The first edge after RST_N rises performs normal updates.

Writes (rising CLK)
- Per register i, priority: WE1 && WA1==i > WE0 && WA0==i > (i==PC_INDEX && PC_INC_EN) > hold.
- PC increment: PC <= PC + PC_STEP, modulo 2^DATA_W (wraps silently; 0xFFFFFFFC + 4 = 0).
- An explicit write to PC_INDEX overrides the increment in the same cycle.
- R0_ZERO=1: register 0 never changes. PC_INDEX must not be 0 when R0_ZERO=1.

Conflict flag
- WR_CONFLICT <= WE0 && WE1 && (WA0==WA1), every edge.
- Set regardless of address, including 0 and PC_INDEX.
- Cleared on the next edge without a conflict.

Reads (combinational, zero latency)
- Px = reg[RA_x], with R0_ZERO=1 forcing 0 for address 0.
- BYPASS=1: if WE1 && WA1==RA_x, Px = WD1; else if WE0 && WA0==RA_x, Px = WD0.
- Bypass is suppressed for address 0 when R0_ZERO=1.
- PC increment is never bypassed; reads of PC_INDEX show the pre-increment value.
- BYPASS=0: reads always return stored (pre-edge) contents.
- Ports A, B, S are independent; identical addresses on all three are legal.
- PC_Q is always the stored PC value and is never bypassed.

Widths
- Addresses are exactly AW bits; no out-of-range case exists.
- No sign or zero extension inside the block.

Test Plan:
1. Reset then read: RST_N=0 -> PA/PB/PS=0, PC_Q=RESET_PC (run with RESET_PC=0x100: reading addr 15 gives 0x100), WR_CONFLICT=0. Assert RST_N=0 asynchronously between edges -> outputs clear before the next edge.
2. Single write/readback: WE0=1, WA0=5, WD0=0xDEADBEEF, one edge -> RA_A=5 gives PA=0xDEADBEEF. WE0=1, WA0=0, WD0=0x1234 -> PA=0 on RA_A=0 (R0_ZERO=1).
3. Dual-write collision: WE0=WE1=1, WA0=WA1=7, WD0=0x11, WD1=0x22 -> reg7=0x22, WR_CONFLICT=1 for exactly one cycle. Next cycle with no writes -> WR_CONFLICT=0.
4. PC behaviour:
   - PC_INC_EN=1 for 3 edges from 0 -> PC_Q=12.
   - Same cycle WE0 to 15 with 0x80 -> PC_Q=0x80, not 0x10.
   - PC=0xFFFFFFFC plus one increment -> PC_Q=0.
5. Bypass: BYPASS=1, reg3=0xA, WE0=1, WA0=3, WD0=0xB, RA_B=3 before the edge -> PB=0xB. Repeat with BYPASS=0 -> PB=0xA pre-edge, 0xB post-edge.
6. Parameter sweep: DATA_W=16, NUM_REGS=8, PC_INDEX=7, PC_STEP=2 -> write/read all 8 registers with address-pattern data. PC wraps 0xFFFE -> 0x0000.
